// File: rtl/sonic_echo_emulator_if.sv
`default_nettype none
// ============================================================================
// Interface : sonic_echo_emulator_if
// Brief     : Ranging link between the trig initiator and the echo responder.
// Revision  : 1.0
// ============================================================================
interface sonic_echo_emulator_if;
    logic       trig;
    logic [9:0] dist_cm;
    logic       obj_present;
    logic       echo;
    logic       busy;
    logic       meas_done;
    logic       trig_err;

    modport master (
        output trig, dist_cm, obj_present,
        input  echo, busy, meas_done, trig_err
    );

    modport slave (
        input  trig, dist_cm, obj_present,
        output echo, busy, meas_done, trig_err
    );
endinterface
`default_nettype wire

// File: rtl/sonic_echo_emulator.sv
`default_nettype none
// ============================================================================
// Module   : sonic_echo_emulator
// Brief    : HC-SR04-style responder; answers each valid trig with an echo
//            whose width encodes the programmed distance.
// Revision : 1.0
// ============================================================================
module sonic_echo_emulator #(
    parameter int CLK_HZ         = 100_000_000,
    parameter int TRIG_MIN_US    = 10,
    parameter int BURST_DELAY_US = 250,
    parameter int US_PER_CM      = 58,
    parameter int MAX_CM         = 400,
    parameter int TIMEOUT_US     = 38000,
    parameter int HOLDOFF_US     = 10000
) (
    input  wire logic              clk,
    input  wire logic              reset,
    sonic_echo_emulator_if.slave   bus
);

    localparam int c_CYC      = CLK_HZ / 1_000_000;
    localparam int c_TRIG_CYC = TRIG_MIN_US * c_CYC;
    localparam int c_CW       = (c_CYC > 1) ? $clog2(c_CYC) : 1;
    localparam int c_WW       = $clog2(c_TRIG_CYC + 1);

    localparam logic [c_CW-1:0] c_CYC_LAST   = c_CW'(c_CYC - 1);
    localparam logic [c_WW-1:0] c_WIDTH_MIN  = c_WW'(c_TRIG_CYC - 1);
    localparam logic [c_WW-1:0] c_WIDTH_SAT  = c_WW'(c_TRIG_CYC);
    localparam logic [15:0]     c_DELAY_LAST = 16'(BURST_DELAY_US - 1);
    localparam logic [15:0]     c_HOLD_LAST  = 16'(HOLDOFF_US - 1);
    localparam logic [15:0]     c_TIMEOUT    = 16'(TIMEOUT_US);
    localparam logic [15:0]     c_US_PER_CM  = 16'(US_PER_CM);
    localparam logic [9:0]      c_MAX_CM     = 10'(MAX_CM);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_TRIG_MEAS = 3'd1;
    localparam logic [2:0] c_ST_DELAY     = 3'd2;
    localparam logic [2:0] c_ST_ECHO      = 3'd3;
    localparam logic [2:0] c_ST_HOLDOFF   = 3'd4;

    logic [2:0]      r_state;
    logic            r_trig_meta;
    logic            r_trig_s;
    logic            r_trig_d;
    logic            r_rise;
    logic            r_fall;
    logic [c_CW-1:0] r_cyc;
    logic [15:0]     r_us;
    logic [c_WW-1:0] r_width;
    logic [15:0]     r_echo_us;
    logic            r_echo;
    logic            r_busy;
    logic            r_meas_done;
    logic            r_trig_err;

    logic            w_us_tick;
    logic            w_delay_last;
    logic            w_echo_last;
    logic            w_hold_last;
    logic [9:0]      w_dist_clip;
    logic [15:0]     w_echo_calc;

    assign w_us_tick    = (r_cyc == c_CYC_LAST);
    assign w_delay_last = w_us_tick && (r_us == c_DELAY_LAST);
    assign w_echo_last  = w_us_tick && (r_us == r_echo_us - 16'd1);
    assign w_hold_last  = w_us_tick && (r_us == c_HOLD_LAST);
    assign w_dist_clip  = (bus.dist_cm > c_MAX_CM) ? c_MAX_CM : bus.dist_cm;
    assign w_echo_calc  = bus.obj_present ? (16'(w_dist_clip) * c_US_PER_CM) : c_TIMEOUT;

    // Edge pulses are registered once more after the synchroniser, which sets
    // the fixed 3-clock front-end latency seen from the trig pin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_trig_meta <= 1'b0;
            r_trig_s    <= 1'b0;
            r_trig_d    <= 1'b0;
            r_rise      <= 1'b0;
            r_fall      <= 1'b0;
            r_cyc       <= '0;
            r_us        <= '0;
            r_width     <= '0;
            r_echo_us   <= '0;
            r_echo      <= 1'b0;
            r_busy      <= 1'b0;
            r_meas_done <= 1'b0;
            r_trig_err  <= 1'b0;
        end else begin
            r_trig_meta <= bus.trig;
            r_trig_s    <= r_trig_meta;
            r_trig_d    <= r_trig_s;
            r_rise      <= r_trig_s & ~r_trig_d;
            r_fall      <= ~r_trig_s & r_trig_d;
            r_meas_done <= 1'b0;
            r_trig_err  <= 1'b0;

            if (w_us_tick) begin
                r_cyc <= '0;
                r_us  <= r_us + 16'd1;
            end else begin
                r_cyc <= r_cyc + c_CW'(1);
            end

            case (r_state)
                c_ST_IDLE: begin
                    r_cyc   <= '0;
                    r_us    <= '0;
                    r_width <= '0;
                    if (r_rise) begin
                        r_state <= c_ST_TRIG_MEAS;
                        r_busy  <= 1'b1;
                    end
                end
                c_ST_TRIG_MEAS: begin
                    r_cyc <= '0;
                    r_us  <= '0;
                    if (r_fall) begin
                        r_width <= '0;
                        // The falling cycle itself completes the pulse width.
                        if (r_width >= c_WIDTH_MIN) begin
                            r_state   <= c_ST_DELAY;
                            r_echo_us <= w_echo_calc;
                        end else begin
                            r_state    <= c_ST_IDLE;
                            r_busy     <= 1'b0;
                            r_trig_err <= 1'b1;
                        end
                    end else if (r_width != c_WIDTH_SAT) begin
                        r_width <= r_width + c_WW'(1);
                    end
                end
                c_ST_DELAY: begin
                    if (w_delay_last) begin
                        r_cyc <= '0;
                        r_us  <= '0;
                        if (r_echo_us != 16'd0) begin
                            r_state <= c_ST_ECHO;
                            r_echo  <= 1'b1;
                        end else begin
                            r_state     <= c_ST_HOLDOFF;
                            r_meas_done <= 1'b1;
                        end
                    end
                end
                c_ST_ECHO: begin
                    if (w_echo_last) begin
                        r_cyc       <= '0;
                        r_us        <= '0;
                        r_state     <= c_ST_HOLDOFF;
                        r_echo      <= 1'b0;
                        r_meas_done <= 1'b1;
                    end
                end
                c_ST_HOLDOFF: begin
                    if (w_hold_last) begin
                        r_cyc   <= '0;
                        r_us    <= '0;
                        r_state <= c_ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_cyc   <= '0;
                    r_us    <= '0;
                    r_state <= c_ST_IDLE;
                    r_echo  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.echo      = r_echo;
    assign bus.busy      = r_busy;
    assign bus.meas_done = r_meas_done;
    assign bus.trig_err  = r_trig_err;

endmodule
`default_nettype wire

// File: tb/tb_sonic_echo_emulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_sonic_echo_emulator
// Brief    : Checks sonic_echo_emulator against a timeline model of the echo
//            protocol, with directed corner cases and random traffic.
// Revision : 1.0
// ============================================================================
module tb_sonic_echo_emulator;

    localparam int CLK_HZ         = 4_000_000;
    localparam int TRIG_MIN_US    = 10;
    localparam int BURST_DELAY_US = 25;
    localparam int US_PER_CM      = 3;
    localparam int MAX_CM         = 400;
    localparam int TIMEOUT_US     = 2000;
    localparam int HOLDOFF_US     = 50;

    localparam int CYC      = CLK_HZ / 1_000_000;
    localparam int TRIG_CYC = TRIG_MIN_US * CYC;
    localparam int DLY      = BURST_DELAY_US * CYC;
    localparam int HOLD     = HOLDOFF_US * CYC;
    localparam int NEVER    = 32'h7fff_ffff;

    logic clk = 1'b0;
    logic reset;
    sonic_echo_emulator_if bus();

    sonic_echo_emulator #(
        .CLK_HZ         (CLK_HZ),
        .TRIG_MIN_US    (TRIG_MIN_US),
        .BURST_DELAY_US (BURST_DELAY_US),
        .US_PER_CM      (US_PER_CM),
        .MAX_CM         (MAX_CM),
        .TIMEOUT_US     (TIMEOUT_US),
        .HOLDOFF_US     (HOLDOFF_US)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected-output timeline, in posedge indices.
    int m_busy_from = 0, m_busy_to = 0;
    int m_echo_from = 0, m_echo_to = 0;
    int m_done_at = -1, m_err_at = -1;
    int m_idle_at = 0;
    int last_fall = 0;

    int checks = 0, errors = 0;
    int rises = 0, dones = 0, errs = 0, last_rise = 0, last_width = 0;
    logic prev_echo = 1'b0;
    int r0, d0, e0, gap, w;

    function automatic int model_echo_us(input int d, input bit obj);
        if (!obj) return TIMEOUT_US;
        return ((d > MAX_CM) ? MAX_CM : d) * US_PER_CM;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : compare
        bit e_echo, e_busy, e_done, e_err;
        e_busy = !reset && cyc >= m_busy_from && cyc < m_busy_to;
        e_echo = !reset && cyc >= m_echo_from && cyc < m_echo_to;
        e_done = !reset && cyc == m_done_at;
        e_err  = !reset && cyc == m_err_at;
        check("echo",      int'(bus.echo),      int'(e_echo));
        check("busy",      int'(bus.busy),      int'(e_busy));
        check("meas_done", int'(bus.meas_done), int'(e_done));
        check("trig_err",  int'(bus.trig_err),  int'(e_err));
        if (bus.echo && !prev_echo) begin
            rises++;
            last_rise = cyc;
        end
        if (!bus.echo && prev_echo) last_width = cyc - last_rise;
        if (bus.meas_done) dones++;
        if (bus.trig_err) errs++;
        prev_echo = bus.echo;
    end

    // Drives one trig pulse of w_in clocks and schedules the expected response.
    // A rise is taken only if the responder is idle when the edge arrives.
    task automatic pulse(input int w_in);
        int wc, p, f;
        bit acc;
        wc = (w_in < 3) ? 3 : w_in;
        @(negedge clk);
        bus.trig = 1'b1;
        p = cyc + 1;
        acc = (m_idle_at <= p + 2);
        for (int i = 0; i < wc; i++) begin
            @(negedge clk);
            if (acc && cyc == p + 2) begin
                m_busy_from = p + 3;
                m_busy_to   = NEVER;
            end
        end
        bus.trig = 1'b0;
        f = cyc + 1;
        last_fall = f;
        if (acc) begin
            if (wc < TRIG_CYC) begin
                m_err_at  = f + 3;
                m_busy_to = f + 3;
                m_idle_at = f + 3;
            end else begin
                m_echo_from = f + 3 + DLY;
                m_echo_to   = m_echo_from + model_echo_us(int'(bus.dist_cm), bus.obj_present) * CYC;
                m_done_at   = m_echo_to;
                m_busy_to   = m_done_at + HOLD;
                m_idle_at   = m_busy_to;
            end
        end
    endtask

    task automatic wait_idle();
        while (cyc < m_idle_at + 2) @(negedge clk);
    endtask

    task automatic model_reset();
        m_busy_from = 0; m_busy_to = 0;
        m_echo_from = 0; m_echo_to = 0;
        m_done_at = -1;  m_err_at = -1;
        m_idle_at = 0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: run exceeded its time limit at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        reset = 1'b1;
        bus.trig = 1'b0;
        bus.dist_cm = 10'd0;
        bus.obj_present = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_echo",      int'(bus.echo),      0);
        check("rst_busy",      int'(bus.busy),      0);
        check("rst_meas_done", int'(bus.meas_done), 0);
        check("rst_trig_err",  int'(bus.trig_err),  0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Minimum valid pulse, 100 cm
        bus.dist_cm = 10'd100;
        r0 = rises; d0 = dones;
        pulse(TRIG_CYC);
        wait_idle();
        check("t1_rises",   rises - r0, 1);
        check("t1_width",   last_width, 1200);
        check("t1_latency", last_rise - last_fall, 103);
        check("t1_done",    dones - d0, 1);

        // One clock short of the minimum
        r0 = rises; e0 = errs;
        pulse(TRIG_CYC - 1);
        wait_idle();
        check("t2_err",   errs - e0, 1);
        check("t2_rises", rises - r0, 0);

        // No object present
        bus.obj_present = 1'b0;
        pulse(TRIG_CYC);
        wait_idle();
        check("t3_width", last_width, 8000);
        bus.obj_present = 1'b1;

        // Distance saturation and zero distance
        bus.dist_cm = 10'd1000;
        pulse(TRIG_CYC);
        wait_idle();
        check("t4_sat_width", last_width, 4800);
        bus.dist_cm = 10'd0;
        r0 = rises; d0 = dones;
        pulse(TRIG_CYC);
        wait_idle();
        check("t4_zero_rises", rises - r0, 0);
        check("t4_zero_done",  dones - d0, 1);

        // Retrigger during ECHO and HOLDOFF, distance change mid-ECHO
        bus.dist_cm = 10'd50;
        r0 = rises; d0 = dones; e0 = errs;
        pulse(TRIG_CYC);
        while (cyc < m_echo_from + 10) @(negedge clk);
        pulse(TRIG_CYC);
        bus.dist_cm = 10'd80;
        while (cyc < m_done_at + 20) @(negedge clk);
        pulse(TRIG_CYC);
        wait_idle();
        check("t5_rises", rises - r0, 1);
        check("t5_width", last_width, 600);
        check("t5_done",  dones - d0, 1);
        check("t5_err",   errs - e0, 0);

        // Trig held high across HOLDOFF exit, then a pulse 1 us after exit
        r0 = rises;
        pulse(TRIG_CYC);
        while (cyc < m_idle_at - 50) @(negedge clk);
        pulse(100);
        repeat (10) @(negedge clk);
        check("t5_held_rises", rises - r0, 1);
        check("t5_held_busy",  int'(bus.busy), 0);
        pulse(TRIG_CYC);
        while (cyc < m_idle_at + CYC - 1) @(negedge clk);
        pulse(TRIG_CYC);
        wait_idle();
        check("t5_after_rises", rises - r0, 3);
        check("t5_after_width", last_width, 960);

        // Asynchronous reset mid-ECHO
        bus.dist_cm = 10'd200;
        pulse(TRIG_CYC);
        while (cyc < m_echo_from + 50) @(negedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        check("t6_echo_async", int'(bus.echo), 0);
        check("t6_busy_async", int'(bus.busy), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        bus.dist_cm = 10'd100;
        r0 = rises;
        pulse(TRIG_CYC);
        wait_idle();
        check("t6_rises", rises - r0, 1);
        check("t6_width", last_width, 1200);

        // Random traffic, overlapping pulses are resolved by the model
        for (int i = 0; i < 20; i++) begin
            bus.dist_cm = 10'($urandom_range(0, 150));
            bus.obj_present = ($urandom_range(0, 15) != 0);
            w = $urandom_range(TRIG_CYC - 15, TRIG_CYC + 15);
            gap = $urandom_range(1, 400);
            pulse(w);
            repeat (4) @(negedge clk);
            repeat (gap) @(negedge clk);
        end
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
